// File: rtl/lsu_data_memory.sv
// Byte-addressed data memory for the load/store path: one request per cycle in,
// one registered response out, with sub-word lane merging and load extension.
module lsu_data_memory #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter logic [31:0] INIT_VALUE  = 32'hAFAFAFAF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_error_o
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic {EMPTY, FULL} state_e;

    state_e      state_q;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    // Word 0 powers up as zero so a null-pointer load is deterministic.
    logic [31:0] mem_q [DEPTH_WORDS] = '{0: 32'h0, default: INIT_VALUE};

    logic             accept, wr_en, size_bad, misalign, out_of_range;
    logic [1:0]       lane;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word, load_data, wr_word;
    logic [3:0]       be;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    assign rsp_valid_o = (state_q == FULL);
    assign req_ready_o = !rsp_valid_o || rsp_ready_i;
    assign rsp_rdata_o = rdata_q;
    assign rsp_error_o = error_q;

    assign lane         = req_addr_i[1:0];
    assign word_idx     = req_addr_i[IDX_W+1:2];
    assign out_of_range = {2'b00, req_addr_i[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(DEPTH_WORDS);
    assign accept       = req_valid_i && req_ready_o;
    assign rd_word      = mem_q[word_idx];

    always_comb begin
        size_bad  = 1'b0;
        misalign  = 1'b0;
        be        = 4'b0000;
        wr_word   = req_wdata_i;
        case (req_size_i)
            2'b00: begin
                be      = 4'b0001 << lane;
                wr_word = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                misalign = lane[0];
                be       = 4'b0011 << {lane[1], 1'b0};
                wr_word  = {2{req_wdata_i[15:0]}};
            end
            2'b10: begin
                misalign = (lane != 2'b00);
                be       = 4'b1111;
            end
            default: size_bad = 1'b1;
        endcase
    end

    always_comb begin
        case (lane)
            2'b00:   byte_sel = rd_word[7:0];
            2'b01:   byte_sel = rd_word[15:8];
            2'b10:   byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (req_size_i)
            2'b00:   load_data = req_unsigned_i ? {24'h0, byte_sel}
                                                : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = req_unsigned_i ? {16'h0, half_sel}
                                                : {{16{half_sel[15]}}, half_sel};
            default: load_data = rd_word;
        endcase
        error_d = size_bad || misalign || out_of_range;
        rdata_d = (error_d || req_write_i) ? 32'h0 : load_data;
    end

    assign wr_en = accept && req_write_i && !error_d;

    // Reset gates the write so a store presented during reset is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            rdata_q <= 32'h0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= FULL;
                        rdata_q <= rdata_d;
                        error_q <= error_d;
                    end
                end
                default: begin
                    if (accept) begin
                        rdata_q <= rdata_d;
                        error_q <= error_d;
                    end else if (rsp_ready_i) begin
                        state_q <= EMPTY;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_data_memory.sv
// Self-checking bench for lsu_data_memory: table of accesses plus hand-written
// throughput, backpressure and mid-operation reset sequences, all via a scoreboard.
module tb_lsu_data_memory;
    localparam int DW = 256;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_write, req_uns, rsp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    lsu_data_memory #(.DEPTH_WORDS(DW), .ADDR_WIDTH(32), .INIT_VALUE(32'hAFAFAFAF)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_uns),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_err)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          id;
    } exp_t;

    int   checks = 0, errors = 0, cyc = 0, nid = 0, acc_cyc = 0;
    exp_t sb[$];
    int   rsp_cyc[$];
    vec_t tbl[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(logic wr, logic [1:0] sz, logic uns, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] er, logic ee);
        vec_t v;
        v.wr = wr; v.sz = sz; v.uns = uns; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Compare the response that the coming edge will consume.
    task automatic mon();
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp got rdata %h err %b want none", rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                check($sformatf("rsp%0d_rdata", e.id), rsp_rdata, e.rdata);
                check($sformatf("rsp%0d_err", e.id), 32'(rsp_err), 32'(e.err));
                rsp_cyc.push_back(cyc);
            end
        end
    endtask

    // Called just after a negedge; returns at the negedge after acceptance.
    task automatic issue(input vec_t v);
        int n;
        n = 0;
        req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_uns = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        #1; mon();
        while (!req_ready && n < 20) begin
            @(negedge clk); #1; mon(); n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout got ready 0 want 1");
        end else begin
            sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, id: nid});
            nid++;
            acc_cyc = cyc + 1;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            #1; mon(); @(negedge clk);
        end
    endtask

    initial begin
        int first_acc;
        localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = W; req_uns = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        tbl.push_back(mk(0, W, 0, 32'h0,   32'h0,        32'h00000000, 0));
        tbl.push_back(mk(0, W, 0, 32'h4,   32'h0,        32'hAFAFAFAF, 0));
        tbl.push_back(mk(1, W, 0, 32'h10,  32'h11223344, 32'h0,        0));
        tbl.push_back(mk(1, B, 0, 32'h11,  32'h12345680, 32'h0,        0));
        tbl.push_back(mk(1, H, 0, 32'h12,  32'h9999BEEF, 32'h0,        0));
        tbl.push_back(mk(0, W, 0, 32'h10,  32'h0,        32'hBEEF8044, 0));
        tbl.push_back(mk(0, B, 0, 32'h11,  32'h0,        32'hFFFFFF80, 0));
        tbl.push_back(mk(0, B, 1, 32'h11,  32'h0,        32'h00000080, 0));
        tbl.push_back(mk(0, H, 0, 32'h12,  32'h0,        32'hFFFFBEEF, 0));
        tbl.push_back(mk(0, H, 1, 32'h12,  32'h0,        32'h0000BEEF, 0));
        tbl.push_back(mk(0, B, 0, 32'h13,  32'h0,        32'hFFFFFFBE, 0));
        tbl.push_back(mk(0, H, 0, 32'h10,  32'h0,        32'hFFFF8044, 0));
        tbl.push_back(mk(0, W, 1, 32'h10,  32'h0,        32'hBEEF8044, 0));
        tbl.push_back(mk(0, W, 0, 32'h6,   32'h0,        32'h0,        1));
        tbl.push_back(mk(1, H, 0, 32'h21,  32'h1234,     32'h0,        1));
        tbl.push_back(mk(0, W, 0, 32'h20,  32'h0,        32'hAFAFAFAF, 0));
        tbl.push_back(mk(0, W, 0, 32'h400, 32'h0,        32'h0,        1));
        tbl.push_back(mk(1, W, 0, 32'h400, 32'h01020304, 32'h0,        1));
        tbl.push_back(mk(0, X, 0, 32'h8,   32'h0,        32'h0,        1));
        tbl.push_back(mk(1, X, 0, 32'h20,  32'h0,        32'h0,        1));
        tbl.push_back(mk(0, W, 0, 32'h20,  32'h0,        32'hAFAFAFAF, 0));
        tbl.push_back(mk(0, H, 0, 32'h1,   32'h0,        32'h0,        1));
        tbl.push_back(mk(1, B, 0, 32'h3FF, 32'hFFFFFF5A, 32'h0,        0));
        tbl.push_back(mk(0, B, 1, 32'h3FF, 32'h0,        32'h0000005A, 0));
        tbl.push_back(mk(0, W, 0, 32'h3FC, 32'h0,        32'h5AAFAFAF, 0));

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_req_ready", 32'(req_ready), 32'h1);

        foreach (tbl[i]) issue(tbl[i]);
        idle(2);

        // Throughput: eight back-to-back loads, one response per cycle.
        rsp_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            issue(mk(0, W, 0, 32'(i * 4), 32'h0,
                     (i == 0) ? 32'h0 : (i == 4) ? 32'hBEEF8044 : 32'hAFAFAFAF, 0));
            if (i == 0) first_acc = acc_cyc;
        end
        idle(2);
        check("tput_count", 32'(rsp_cyc.size()), 32'd8);
        if (rsp_cyc.size() == 8) begin
            check("tput_first", 32'(rsp_cyc[0]), 32'(first_acc));
            for (int i = 1; i < 8; i++)
                check($sformatf("tput_cyc%0d", i), 32'(rsp_cyc[i]), 32'(rsp_cyc[0] + i));
        end

        // Backpressure: held response, store waiting on req.
        rsp_ready = 1'b0;
        issue(mk(0, W, 0, 32'h10, 32'h0, 32'hBEEF8044, 0));
        req_valid = 1'b1; req_write = 1'b1; req_size = W; req_uns = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h55667788;
        for (int i = 0; i < 3; i++) begin
            #1; mon();
            check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'h1);
            check($sformatf("bp_rdata%0d", i), rsp_rdata, 32'hBEEF8044);
            check($sformatf("bp_err%0d", i), 32'(rsp_err), 32'h0);
            check($sformatf("bp_ready%0d", i), 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'h1);
        issue(mk(1, W, 0, 32'h40, 32'h55667788, 32'h0, 0));
        issue(mk(0, W, 0, 32'h40, 32'h0, 32'h55667788, 0));
        idle(2);

        // Reset with a pending response and a store presented.
        rsp_ready = 1'b0;
        issue(mk(0, W, 0, 32'h0, 32'h0, 32'h0, 0));
        #1;
        check("rst_pending_valid", 32'(rsp_valid), 32'h1);
        req_valid = 1'b1; req_write = 1'b1; req_size = W;
        req_addr = 32'h30; req_wdata = 32'hDEADBEEF;
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_valid", 32'(rsp_valid), 32'h0);
        sb.delete();
        rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        check("rst_mid_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        issue(mk(0, W, 0, 32'h30, 32'h0, 32'hAFAFAFAF, 0));
        idle(3);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
